l2_request_arbiter: RTL and testbench
=====================================

# l2_request_arbiter

Two-port arbiter sitting directly upstream of the level-two cache. It merges the instruction L1 miss port and the data L1 miss/writeback port into the single 256-bit line port of the level-two cache. It latches one request at a time, holds it stable toward L2 until L2 responds, and returns the line to the winning requester as a registered one-cycle response. The data port wins on ties by default; round-robin is optional at compile time.

## Interface
- No parameters. Widths are fixed: address 32, line 256.
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_addr  in  32  instruction L1 line address
- i_read  in  1  instruction L1 line read request; level, held until i_resp
- i_rdata  out  256  line returned to instruction L1; valid when i_resp=1
- i_resp  out  1  one-cycle completion pulse to instruction L1
- d_addr  in  32  data L1 line address
- d_read  in  1  data L1 line read request; level
- d_write  in  1  data L1 line writeback request; level
- d_wdata  in  256  writeback line
- d_rdata  out  256  line returned to data L1; valid when d_resp=1
- d_resp  out  1  one-cycle completion pulse to data L1
- addr_to_level_two_cache  out  32  latched address
- wdata_to_level_two_cache  out  256  latched write line
- read_to_level_two_cache  out  1  L2 read strobe
- write_to_level_two_cache  out  1  L2 write strobe
- rdata_from_level_two_cache  in  256  L2 read line
- resp_from_level_two_cache  in  1  L2 completion

## Operation
- States: IDLE, GRANT_I, GRANT_D, RESP_I, RESP_D.
- IDLE:
  - Sample requests; i_req = i_read; d_req = d_read | d_write.
  - Winner's addr, wdata and op are latched into request registers; next state is GRANT_x.
  - No request: stay in IDLE.
- GRANT_x:
  - addr/wdata outputs come from the latched registers.
  - read_to_level_two_cache = latched read; write_to_level_two_cache = latched write.
  - Both strobes are 0 in every other state.
  - On resp_from_level_two_cache=1, capture rdata_from_level_two_cache into the response register and go to RESP_x.
- RESP_x: assert x_resp=1 with x_rdata = captured line for exactly one cycle, then go to IDLE.
- Both d_read and d_write high: write is latched and read is ignored (illegal input; logged by an assertion).
- resp_from_level_two_cache in IDLE or RESP_x is ignored.
- Input changes during GRANT_x have no effect, because the request is latched.
- i_rdata/d_rdata hold the last captured line between responses. Only the resp pulse qualifies them.

## Timing
- Reset values (asynchronous):
  - State = IDLE.
  - All strobes and resp outputs = 0.
  - addr/wdata/rdata registers = 0.
  - Priority pointer = data.
- Latency:
  - Request seen in IDLE at cycle 0.
  - L2 strobe is high from cycle 1.
  - L2 resp at cycle N leads to x_resp at cycle N+1.
  - IDLE at cycle N+2; earliest next grant strobe at N+3.
  - Minimum round trip with 1-cycle L2: resp to L1 at cycle 2.
- The L2 strobe drops in the cycle after resp_from_level_two_cache. No double issue.
- The RESP state guarantees the L1 has deasserted its request before IDLE resamples.
- Reset asserted mid-GRANT: the transaction is abandoned, strobes drop asynchronously, and no resp is issued. After release, pending L1 requests are re-arbitrated from IDLE.

## Configuration
- ARBITER_ROUND_ROBIN_EN undefined: fixed priority. Data beats instruction whenever both are requesting in IDLE.
- ARBITER_ROUND_ROBIN_EN defined:
  - A one-bit last-grant register (reset = data) updates on every grant.
  - On a tie, the port not granted last wins.
  - A lone requester always wins regardless of the pointer.

## Test plan
- Single instruction read, i_addr=0x0000_1000, L2 resp after 3 cycles with line 0xA5…A5:
  - read_to_level_two_cache high cycles 1–3, addr=0x0000_1000.
  - i_resp=1 in cycle 4 with i_rdata=0xA5…A5; d_resp stays 0.
- Data writeback, d_write=1, d_addr=0x0000_2040, d_wdata=0x1234…:
  - write_to_level_two_cache high with matching addr/wdata; read strobe 0.
  - d_resp pulse one cycle after L2 resp.
- Simultaneous i_read and d_read held across two transactions:
  - Fixed priority: D served, then I.
  - With macro and a third tie: order D, I, D.
- Back-to-back: L1 reissues d_read in the cycle after d_resp.
  - The new strobe appears exactly 2 cycles after the resp pulse.
  - The old request is never reissued.
- reset_n pulsed low during GRANT_D:
  - Strobes are 0 immediately; no d_resp.
  - After release with d_read still high, the request is regranted from IDLE.
- Spurious resp_from_level_two_cache=1 in IDLE: no state change, no resp outputs.

Source files
------------

// File: rtl/l2_request_arbiter.sv
// Two-port (instruction / data) arbiter in front of the 256-bit L2 line port.
// Optional compile-time macro ARBITER_ROUND_ROBIN_EN replaces fixed data priority with round-robin.
module l2_request_arbiter (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [31:0]  i_addr,
   input  logic         i_read,
   output logic [255:0] i_rdata,
   output logic         i_resp,
   input  logic [31:0]  d_addr,
   input  logic         d_read,
   input  logic         d_write,
   input  logic [255:0] d_wdata,
   output logic [255:0] d_rdata,
   output logic         d_resp,
   output logic [31:0]  addr_to_level_two_cache,
   output logic [255:0] wdata_to_level_two_cache,
   output logic         read_to_level_two_cache,
   output logic         write_to_level_two_cache,
   input  logic [255:0] rdata_from_level_two_cache,
   input  logic         resp_from_level_two_cache
);

   typedef enum logic [2:0] {IDLE, GRANT_I, GRANT_D, RESP_I, RESP_D} state_t;

   state_t         state_reg, state_next;
   logic [31:0]    addr_reg, addr_next;
   logic [255:0]   wdata_reg, wdata_next;
   logic           read_reg, read_next;
   logic           write_reg, write_next;
   logic [255:0]   i_rdata_reg, i_rdata_next;
   logic [255:0]   d_rdata_reg, d_rdata_next;
   logic           i_req, d_req, d_wins, granting;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

`ifdef ARBITER_ROUND_ROBIN_EN
   // last_d_reg = 1 when the data port won the previous grant; the other port wins ties
   logic last_d_reg, last_d_next;
   assign d_wins = d_req & (~i_req | ~last_d_reg);
`else
   assign d_wins = d_req;
`endif

   assign granting = (state_reg == GRANT_I) || (state_reg == GRANT_D);

   always_comb begin
      state_next   = state_reg;
      addr_next    = addr_reg;
      wdata_next   = wdata_reg;
      read_next    = read_reg;
      write_next   = write_reg;
      i_rdata_next = i_rdata_reg;
      d_rdata_next = d_rdata_reg;
`ifdef ARBITER_ROUND_ROBIN_EN
      last_d_next  = last_d_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (d_wins) begin
               // a simultaneous read+write is illegal; the write takes precedence
               addr_next  = d_addr;
               wdata_next = d_wdata;
               write_next = d_write;
               read_next  = ~d_write;
               state_next = GRANT_D;
`ifdef ARBITER_ROUND_ROBIN_EN
               last_d_next = 1'b1;
`endif
            end else if (i_req) begin
               addr_next  = i_addr;
               wdata_next = '0;
               write_next = 1'b0;
               read_next  = 1'b1;
               state_next = GRANT_I;
`ifdef ARBITER_ROUND_ROBIN_EN
               last_d_next = 1'b0;
`endif
            end
         end
         GRANT_I: begin
            if (resp_from_level_two_cache) begin
               i_rdata_next = rdata_from_level_two_cache;
               state_next   = RESP_I;
            end
         end
         GRANT_D: begin
            if (resp_from_level_two_cache) begin
               d_rdata_next = rdata_from_level_two_cache;
               state_next   = RESP_D;
            end
         end
         RESP_I:  state_next = IDLE;
         RESP_D:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= IDLE;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         read_reg    <= 1'b0;
         write_reg   <= 1'b0;
         i_rdata_reg <= '0;
         d_rdata_reg <= '0;
`ifdef ARBITER_ROUND_ROBIN_EN
         last_d_reg  <= 1'b1;
`endif
      end else begin
         state_reg   <= state_next;
         addr_reg    <= addr_next;
         wdata_reg   <= wdata_next;
         read_reg    <= read_next;
         write_reg   <= write_next;
         i_rdata_reg <= i_rdata_next;
         d_rdata_reg <= d_rdata_next;
`ifdef ARBITER_ROUND_ROBIN_EN
         last_d_reg  <= last_d_next;
`endif
      end
   end

   // strobes decode straight from state so an asynchronous reset drops them at once
   assign addr_to_level_two_cache  = addr_reg;
   assign wdata_to_level_two_cache = wdata_reg;
   assign read_to_level_two_cache  = granting & read_reg;
   assign write_to_level_two_cache = granting & write_reg;
   assign i_resp  = (state_reg == RESP_I);
   assign d_resp  = (state_reg == RESP_D);
   assign i_rdata = i_rdata_reg;
   assign d_rdata = d_rdata_reg;

   no_read_with_write : assert property (@(posedge clk) disable iff (!reset_n)
      (state_reg == IDLE) |-> !(d_read && d_write));

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter; each scenario task checks its own expected values.
// Define ARBITER_ROUND_ROBIN_EN for both files to exercise the round-robin tie ordering.
module tb_l2_request_arbiter;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [31:0]  i_addr, d_addr;
   logic         i_read, d_read, d_write;
   logic [255:0] d_wdata, rdata_l2;
   logic         resp_l2;
   logic [255:0] i_rdata, d_rdata, wdata_l2;
   logic         i_resp, d_resp, rd_l2, wr_l2;
   logic [31:0]  addr_l2;

   int vectors = 0;
   int errors  = 0;

   localparam logic [255:0] LINE_A5 = {32{8'hA5}};
   localparam logic [255:0] LINE_WB = {8{32'h12345678}};
   localparam logic [255:0] LINE_5A = {32{8'h5A}};
   localparam logic [255:0] LINE_77 = {32{8'h77}};
   localparam logic [255:0] LINE_C3 = {32{8'hC3}};

   always #5 clk = ~clk;

   l2_request_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .addr_to_level_two_cache(addr_l2), .wdata_to_level_two_cache(wdata_l2),
      .read_to_level_two_cache(rd_l2), .write_to_level_two_cache(wr_l2),
      .rdata_from_level_two_cache(rdata_l2), .resp_from_level_two_cache(resp_l2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; i_addr = '0; d_addr = '0; i_read = 0; d_read = 0; d_write = 0;
      d_wdata = '0; rdata_l2 = '0; resp_l2 = 0;
      step(); step();
      vectors++;
      if ({rd_l2, wr_l2, i_resp, d_resp} !== 4'b0000 || addr_l2 !== 32'h0 || wdata_l2 !== '0
          || i_rdata !== '0 || d_rdata !== '0) begin
         errors++;
         $display("FAIL reset: strobes/resp=%b addr=%h (required 0000, 0, all data 0)",
                  {rd_l2, wr_l2, i_resp, d_resp}, addr_l2);
      end
      #2 reset_n = 1'b1;
      step();
      $display("reset: released");
   endtask

   task automatic test_spurious_resp();
      resp_l2 = 1; rdata_l2 = LINE_C3;
      step(); step();
      vectors++;
      if ({rd_l2, wr_l2, i_resp, d_resp} !== 4'b0000 || i_rdata !== '0 || d_rdata !== '0) begin
         errors++;
         $display("FAIL spurious_resp: strobes/resp=%b i_rdata[7:0]=%h d_rdata[7:0]=%h (required 0000, 00, 00)",
                  {rd_l2, wr_l2, i_resp, d_resp}, i_rdata[7:0], d_rdata[7:0]);
      end
      resp_l2 = 0;
      step();
      $display("spurious_resp: done");
   endtask

   task automatic test_single_i_read();
      i_addr = 32'h0000_1000; i_read = 1;             // cycle 0
      for (int c = 1; c <= 3; c++) begin
         step();
         if (c == 3) begin resp_l2 = 1; rdata_l2 = LINE_A5; end
         vectors++;
         if (rd_l2 !== 1'b1 || wr_l2 !== 1'b0 || addr_l2 !== 32'h0000_1000) begin
            errors++;
            $display("FAIL i_read_strobe c%0d: rd=%b wr=%b addr=%h (required 1 0 00001000)", c, rd_l2, wr_l2, addr_l2);
         end
      end
      step();                                         // cycle 4
      resp_l2 = 0;
      vectors++;
      if (i_resp !== 1'b1 || i_rdata !== LINE_A5 || d_resp !== 1'b0 || rd_l2 !== 1'b0) begin
         errors++;
         $display("FAIL i_read_resp: i_resp=%b i_rdata[7:0]=%h d_resp=%b rd=%b (required 1 a5 0 0)",
                  i_resp, i_rdata[7:0], d_resp, rd_l2);
      end
      i_read = 0;
      step();                                         // cycle 5, back in IDLE
      vectors++;
      if (i_resp !== 1'b0 || rd_l2 !== 1'b0) begin
         errors++;
         $display("FAIL i_read_after: i_resp=%b rd=%b (required 0 0)", i_resp, rd_l2);
      end
      step();
      vectors++;
      if (rd_l2 !== 1'b0) begin
         errors++;
         $display("FAIL i_read_no_reissue: rd=%b (required 0)", rd_l2);
      end
      $display("single_i_read: i_rdata[7:0]=%h", i_rdata[7:0]);
   endtask

   // Runs right after an instruction grant, so round-robin starts with data preferred.
   task automatic test_tie();
      i_addr = 32'h0000_1100; d_addr = 32'h0000_2200; i_read = 1; d_read = 1;
      step();                                         // cycle 1
      vectors++;
      if (rd_l2 !== 1'b1 || addr_l2 !== 32'h0000_2200) begin
         errors++;
         $display("FAIL tie_first_d: rd=%b addr=%h (required 1 00002200)", rd_l2, addr_l2);
      end
      resp_l2 = 1; rdata_l2 = LINE_5A;
      step();                                         // cycle 2
      resp_l2 = 0;
      vectors++;
      if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== LINE_5A) begin
         errors++;
         $display("FAIL tie_d_resp: d_resp=%b i_resp=%b d_rdata[7:0]=%h (required 1 0 5a)", d_resp, i_resp, d_rdata[7:0]);
      end
`ifndef ARBITER_ROUND_ROBIN_EN
      d_read = 0;
`endif
      step(); step();                                 // cycle 4: second grant
      vectors++;
      if (rd_l2 !== 1'b1 || addr_l2 !== 32'h0000_1100) begin
         errors++;
         $display("FAIL tie_second_i: rd=%b addr=%h (required 1 00001100)", rd_l2, addr_l2);
      end
      resp_l2 = 1; rdata_l2 = LINE_77;
      step();                                         // cycle 5
      resp_l2 = 0;
      vectors++;
      if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== LINE_77) begin
         errors++;
         $display("FAIL tie_i_resp: i_resp=%b d_resp=%b i_rdata[7:0]=%h (required 1 0 77)", i_resp, d_resp, i_rdata[7:0]);
      end
`ifdef ARBITER_ROUND_ROBIN_EN
      step(); step();                                 // cycle 7: third tie goes to data
      vectors++;
      if (rd_l2 !== 1'b1 || addr_l2 !== 32'h0000_2200) begin
         errors++;
         $display("FAIL tie_third_d: rd=%b addr=%h (required 1 00002200)", rd_l2, addr_l2);
      end
      resp_l2 = 1;
      step();
      resp_l2 = 0;
      vectors++;
      if (d_resp !== 1'b1) begin
         errors++;
         $display("FAIL tie_third_resp: d_resp=%b (required 1)", d_resp);
      end
      d_read = 0;
`endif
      i_read = 0;
      step(); step();
      $display("tie: completed");
   endtask

   task automatic test_writeback();
      d_write = 1; d_addr = 32'h0000_2040; d_wdata = LINE_WB;
      step();                                         // cycle 1
      vectors++;
      if (wr_l2 !== 1'b1 || rd_l2 !== 1'b0 || addr_l2 !== 32'h0000_2040 || wdata_l2 !== LINE_WB) begin
         errors++;
         $display("FAIL wb_strobe: wr=%b rd=%b addr=%h wdata[31:0]=%h (required 1 0 00002040 12345678)",
                  wr_l2, rd_l2, addr_l2, wdata_l2[31:0]);
      end
      step();                                         // cycle 2
      resp_l2 = 1; rdata_l2 = LINE_C3;
      vectors++;
      if (wr_l2 !== 1'b1 || d_resp !== 1'b0) begin
         errors++;
         $display("FAIL wb_hold: wr=%b d_resp=%b (required 1 0)", wr_l2, d_resp);
      end
      step();                                         // cycle 3
      resp_l2 = 0;
      vectors++;
      if (d_resp !== 1'b1 || wr_l2 !== 1'b0 || i_resp !== 1'b0 || i_rdata !== LINE_77) begin
         errors++;
         $display("FAIL wb_resp: d_resp=%b wr=%b i_resp=%b i_rdata[7:0]=%h (required 1 0 0 77)",
                  d_resp, wr_l2, i_resp, i_rdata[7:0]);
      end
      d_write = 0;
      step();
      vectors++;
      if (d_resp !== 1'b0 || d_rdata !== LINE_C3) begin
         errors++;
         $display("FAIL wb_pulse_width: d_resp=%b d_rdata[7:0]=%h (required 0 c3)", d_resp, d_rdata[7:0]);
      end
      $display("writeback: addr=00002040 done");
   endtask

   task automatic test_back_to_back();
      d_read = 1; d_addr = 32'h0000_4000;
      step();                                         // cycle 1
      resp_l2 = 1; rdata_l2 = LINE_77;
      step();                                         // cycle 2: d_resp
      resp_l2 = 0;
      vectors++;
      if (d_resp !== 1'b1 || d_rdata !== LINE_77) begin
         errors++;
         $display("FAIL b2b_first_resp: d_resp=%b d_rdata[7:0]=%h (required 1 77)", d_resp, d_rdata[7:0]);
      end
      d_read = 0;
      step();                                         // cycle 3: reissue
      vectors++;
      if (rd_l2 !== 1'b0 || d_resp !== 1'b0) begin
         errors++;
         $display("FAIL b2b_gap: rd=%b d_resp=%b (required 0 0)", rd_l2, d_resp);
      end
      d_read = 1; d_addr = 32'h0000_4080;
      step();                                         // cycle 4: 2 cycles after resp
      vectors++;
      if (rd_l2 !== 1'b1 || addr_l2 !== 32'h0000_4080) begin
         errors++;
         $display("FAIL b2b_second_strobe: rd=%b addr=%h (required 1 00004080)", rd_l2, addr_l2);
      end
      resp_l2 = 1; rdata_l2 = LINE_A5;
      step();
      resp_l2 = 0; d_read = 0;
      vectors++;
      if (d_resp !== 1'b1 || d_rdata !== LINE_A5) begin
         errors++;
         $display("FAIL b2b_second_resp: d_resp=%b d_rdata[7:0]=%h (required 1 a5)", d_resp, d_rdata[7:0]);
      end
      step();
      $display("back_to_back: done");
   endtask

   task automatic test_reset_mid_grant();
      d_read = 1; d_addr = 32'h0000_3000;
      step();                                         // in GRANT_D
      vectors++;
      if (rd_l2 !== 1'b1) begin
         errors++;
         $display("FAIL rst_grant_pre: rd=%b (required 1)", rd_l2);
      end
      #2 reset_n = 1'b0;
      #1;
      vectors++;
      if (rd_l2 !== 1'b0 || wr_l2 !== 1'b0 || d_resp !== 1'b0 || addr_l2 !== 32'h0) begin
         errors++;
         $display("FAIL rst_async_drop: rd=%b wr=%b d_resp=%b addr=%h (required 0 0 0 0)", rd_l2, wr_l2, d_resp, addr_l2);
      end
      resp_l2 = 1;
      step();
      vectors++;
      if (d_resp !== 1'b0 || rd_l2 !== 1'b0) begin
         errors++;
         $display("FAIL rst_no_resp: d_resp=%b rd=%b (required 0 0)", d_resp, rd_l2);
      end
      resp_l2 = 0;
      #2 reset_n = 1'b1;
      step();                                         // regranted from IDLE
      vectors++;
      if (rd_l2 !== 1'b1 || addr_l2 !== 32'h0000_3000 || d_resp !== 1'b0) begin
         errors++;
         $display("FAIL rst_regrant: rd=%b addr=%h d_resp=%b (required 1 00003000 0)", rd_l2, addr_l2, d_resp);
      end
      resp_l2 = 1; rdata_l2 = LINE_5A;
      step();
      resp_l2 = 0; d_read = 0;
      vectors++;
      if (d_resp !== 1'b1 || d_rdata !== LINE_5A) begin
         errors++;
         $display("FAIL rst_regrant_resp: d_resp=%b d_rdata[7:0]=%h (required 1 5a)", d_resp, d_rdata[7:0]);
      end
      step();
      $display("reset_mid_grant: done");
   endtask

   initial begin
      test_reset();
      test_spurious_resp();
      test_single_i_read();
      test_tie();
      test_writeback();
      test_back_to_back();
      test_reset_mid_grant();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
